// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic light controller: phase enum,
// lamp codes and default phase durations.
package tlc_pkg;

  typedef enum logic [2:0] {
    MG,
    MGX,
    MY,
    WALK,
    SG,
    SGX,
    SY
  } tlc_state_e;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  localparam int DEF_T_BASE = 6;
  localparam int DEF_T_EXT  = 3;
  localparam int DEF_T_YEL  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tlc_interval_timer.sv
// Loadable down-counter stepped by tick; expire flags the tick that consumes
// the last unit of the current interval.
module tlc_interval_timer #(
  parameter int           W         = 3,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         wr_reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A load coincides with the expiring tick, so it must win over the decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge wr_reset) begin
    if (wr_reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = tick && (count_q == W'(1));

endmodule

// File: rtl/traffic_light_controller.sv
// Main/side street light sequencer with an optional pedestrian walk phase.
// Define TLC_WALK_FLASH_EN to make the walk lamp flash near the end of WALK.
module traffic_light_controller
  import tlc_pkg::*;
#(
  parameter int T_BASE = DEF_T_BASE,
  parameter int T_EXT  = DEF_T_EXT,
  parameter int T_YEL  = DEF_T_YEL
) (
  input  logic       clk,
  input  logic       wr_reset,
  input  logic       tick,
  input  logic       wr,
  input  logic       sensor,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_lamp,
  output logic       wr_clear
);

  localparam int CW = $clog2(max3(T_BASE, T_EXT, T_YEL) + 1);

  tlc_state_e state_q;
  tlc_state_e state_d;
  logic       wr_clear_q;
  logic       wr_clear_d;
  logic [CW-1:0] count;
  logic [CW-1:0] load_val;
  logic          expire;

  function automatic logic [CW-1:0] duration_of(input tlc_state_e s);
    case (s)
      MG:      return CW'(T_BASE);
      MY, SY:  return CW'(T_YEL);
      default: return CW'(T_EXT);
    endcase
  endfunction

  tlc_interval_timer #(
    .W        (CW),
    .RESET_VAL(CW'(T_BASE))
  ) u_timer (
    .clk     (clk),
    .wr_reset(wr_reset),
    .load    (expire),
    .load_val(load_val),
    .tick    (tick),
    .count   (count),
    .expire  (expire)
  );

  // wr and sensor only matter on the tick that ends a phase.
  always_comb begin
    state_d    = state_q;
    wr_clear_d = 1'b0;
    if (expire) begin
      case (state_q)
        MG:  state_d = sensor ? MGX : MY;
        MGX: state_d = MY;
        MY: begin
          if (wr) begin
            state_d    = WALK;
            wr_clear_d = 1'b1;
          end else begin
            state_d = SG;
          end
        end
        WALK:    state_d = SG;
        SG:      state_d = sensor ? SGX : SY;
        SGX:     state_d = SY;
        SY:      state_d = MG;
        default: state_d = MG;
      endcase
    end
  end

  assign load_val = duration_of(state_d);

  always_ff @(posedge clk or posedge wr_reset) begin
    if (wr_reset) begin
      state_q    <= MG;
      wr_clear_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_clear_q <= wr_clear_d;
    end
  end

  always_comb begin
    main_light = LIGHT_R;
    side_light = LIGHT_R;
    walk_lamp  = 1'b0;
    case (state_q)
      MG, MGX: main_light = LIGHT_G;
      MY:      main_light = LIGHT_Y;
      SG, SGX: side_light = LIGHT_G;
      SY:      side_light = LIGHT_Y;
      WALK: begin
`ifdef TLC_WALK_FLASH_EN
        walk_lamp = (int'(count) > 2) || count[0];
`else
        walk_lamp = 1'b1;
`endif
      end
      default: begin
        main_light = LIGHT_R;
        side_light = LIGHT_R;
      end
    endcase
  end

`ifndef TLC_WALK_FLASH_EN
  logic unused_count;
  assign unused_count = ^count;
`endif

  assign wr_clear = wr_clear_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed plus randomized bench for traffic_light_controller, checked against
// a phase-table model of the light sequence.
module tb_traffic_light_controller;

  logic       clk;
  logic       wr_reset;
  logic       tick;
  logic       wr;
  logic       sensor;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_lamp;
  logic       wr_clear;

  int n_asserts;
  int n_fail;

  // Model: phase index (0 MG,1 MGX,2 MY,3 WALK,4 SG,5 SGX,6 SY) and ticks spent in it.
  int m_phase;
  int m_done;
  bit m_clear;

  traffic_light_controller #(
    .T_BASE(6),
    .T_EXT (3),
    .T_YEL (2)
  ) dut (
    .clk       (clk),
    .wr_reset  (wr_reset),
    .tick      (tick),
    .wr        (wr),
    .sensor    (sensor),
    .main_light(main_light),
    .side_light(side_light),
    .walk_lamp (walk_lamp),
    .wr_clear  (wr_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int phaseDur(input int p);
    case (p)
      0:       return 6;
      2, 6:    return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [2:0] expMain(input int p);
    if (p == 0 || p == 1) return 3'b001;
    if (p == 2) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] expSide(input int p);
    if (p == 4 || p == 5) return 3'b001;
    if (p == 6) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic expWalk(input int p, input int done);
    int remaining;
    if (p != 3) return 1'b0;
    remaining = phaseDur(p) - done;
`ifdef TLC_WALK_FLASH_EN
    return (remaining > 2) || (remaining % 2 == 1);
`else
    return (remaining > 0);
`endif
  endfunction

  task automatic modelReset();
    m_phase = 0;
    m_done  = 0;
    m_clear = 1'b0;
  endtask

  task automatic modelEdge(input bit t, input bit w, input bit s);
    m_clear = 1'b0;
    if (t) begin
      m_done++;
      if (m_done == phaseDur(m_phase)) begin
        m_done = 0;
        case (m_phase)
          0: m_phase = s ? 1 : 2;
          1: m_phase = 2;
          2: begin
            m_phase = w ? 3 : 4;
            m_clear = w;
          end
          3: m_phase = 4;
          4: m_phase = s ? 5 : 6;
          5: m_phase = 6;
          default: m_phase = 0;
        endcase
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("main_light", main_light, expMain(m_phase));
    checkVal("side_light", side_light, expSide(m_phase));
    checkVal("walk_lamp", {2'b00, walk_lamp}, {2'b00, expWalk(m_phase, m_done)});
    checkVal("wr_clear", {2'b00, wr_clear}, {2'b00, m_clear});
  endtask

  // Drive one clock of inputs, advance the model at the edge, check 1 ns later.
  task automatic applyStimulus(input bit t, input bit w, input bit s);
    tick   = t;
    wr     = w;
    sensor = s;
    @(posedge clk);
    modelEdge(t, w, s);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    wr_reset = 1'b1;
    modelReset();
    #1;
    checkVal("rst_main", main_light, 3'b001);
    checkVal("rst_side", side_light, 3'b100);
    checkVal("rst_walk", {2'b00, walk_lamp}, 3'b000);
    checkVal("rst_clear", {2'b00, wr_clear}, 3'b000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_reset = 1'b0;
  endtask

  initial begin
    logic exp_w;
    n_asserts = 0;
    n_fail    = 0;
    tick      = 1'b0;
    wr        = 1'b0;
    sensor    = 1'b0;
    wr_reset  = 1'b0;
    @(posedge clk); #1;
    doReset();

    // No traffic, no request: 13-tick period with idle clocks between ticks
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (i == 5) checkVal("nt_my_after6", main_light, 3'b010);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkVal("nt_period13_main", main_light, 3'b001);
    checkVal("nt_period13_side", side_light, 3'b100);

    // Mid-run reset aborts immediately
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    doReset();

    // Walk request latched from tick 3 onward
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 3; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (i < 8) applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkVal("wk_clear_pulse", {2'b00, wr_clear}, 3'b001);
    checkVal("wk_main_red", main_light, 3'b100);
    checkVal("wk_side_red", side_light, 3'b100);
    checkVal("wk_lamp_first", {2'b00, walk_lamp}, 3'b001);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkVal("wk_clear_once", {2'b00, wr_clear}, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef TLC_WALK_FLASH_EN
    exp_w = 1'b0;
`else
    exp_w = 1'b1;
`endif
    checkVal("wk_lamp_second", {2'b00, walk_lamp}, {2'b00, exp_w});
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkVal("wk_lamp_third", {2'b00, walk_lamp}, 3'b001);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkVal("wk_then_sg", side_light, 3'b001);

    // Sensor held: 19-tick period through both extensions
    doReset();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (i == 7) checkVal("sn_mgx_green", main_light, 3'b001);
    end
    checkVal("sn_period19_main", main_light, 3'b001);

    // wr on the same clk as MY's final tick is taken
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkVal("ec_walk_taken", {2'b00, walk_lamp}, 3'b001);
    checkVal("ec_clear", {2'b00, wr_clear}, 3'b001);

    // wr one clk late: SG taken, request served next cycle
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkVal("late_sg", side_light, 3'b001);
    checkVal("late_no_clear", {2'b00, wr_clear}, 3'b000);
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkVal("late_walk_next", main_light, 3'b100);
    checkVal("late_walk_side", side_light, 3'b100);
    checkVal("late_clear", {2'b00, wr_clear}, 3'b001);

    // Randomized traffic, requests, tick spacing and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        doReset();
      end else begin
        applyStimulus(($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

- Consumes the latched pedestrian request `wr` and sequences the main-street and side-street lamps and the walk lamp.
- Inserts a walk phase after main yellow when a request is pending, and returns a one-clock `wr_clear` pulse that drops the request latch.
- Sits between the request latch (its `wr_reset` input is driven by `wr_clear` OR the system reset) and the lamp drivers.
- Phase durations are counted in `tick` pulses, each one `clk` cycle wide.

## Interface
- T_BASE, 6: ticks of main-green base interval
- T_EXT, 3: ticks of every extension interval, the walk interval and side-green base
- T_YEL, 2: ticks of each yellow interval
- clk  in  1  system clock, rising edge
- wr_reset  in  1  reset; asynchronous, active-high
- tick  in  1  single-cycle timebase enable (nominally 1 Hz)
- wr  in  1  latched walk request
- sensor  in  1  side-street vehicle sensor, already synchronised
- main_light  out  3  {R,Y,G} one-hot
- side_light  out  3  {R,Y,G} one-hot
- walk_lamp  out  1  pedestrian walk lamp
- wr_clear  out  1  one-clk pulse to the request latch

## Operation
- Every state loads the interval counter with its duration on entry.
- The counter decrements only on `tick`.
- On a `tick` with count==1 the FSM leaves the state at that edge. A state of duration N therefore spans exactly N ticks.
- Durations must be ≥1. Counter width is $clog2(max(T_BASE,T_EXT,T_YEL)+1).

| State | Lamps | Duration | Exit |
|---|---|---|---|
| MG | main G, side R | T_BASE | to MGX if `sensor`==1 at the exit edge, else to MY |
| MGX | main G, side R | T_EXT | to MY |
| MY | main Y, side R | T_YEL | to WALK if `wr`==1 at the exit edge, else to SG |
| WALK | main R, side R, walk_lamp=1 | T_EXT | to SG |
| SG | main R, side G | T_EXT | to SGX if `sensor`==1 at the exit edge, else to SY |
| SGX | main R, side G | T_EXT | to SY |
| SY | main R, side Y | T_YEL | to MG |

- `walk_lamp` is 0 in every state except WALK.
- `wr_clear` is high for exactly the one clk following the edge that enters WALK. It is never asserted in any other cycle.
- `wr` and `sensor` are sampled only at exit edges. Activity at other times is ignored.
- A request set during WALK stays latched and is served on the next cycle.
- Lamp outputs are a Moore decode of the registered state (and of the count under the macro below). Exactly one bit of each light bus is set at all times.

## Timing
- **Reset values:**
  - state MG, count=T_BASE
  - main_light=3'b001, side_light=3'b100
  - walk_lamp=0, wr_clear=0
- `wr_reset` mid-interval aborts immediately. WALK is abandoned without a `wr_clear`, which is acceptable because the latch is reset by the same signal.
- The first tick after reset release counts toward MG.
- A `tick` coincident with deassertion of reset is ignored.
- `tick` on consecutive clocks is legal. Each pulse decrements once.
- Latency from the exit tick to the lamp change: 1 clk (same edge as the state update).
- `wr` rising on the same edge that exits MY is seen, so WALK is entered.
- `sensor` falling on the exit edge of MG is seen as 0, so the FSM goes to MY.

## Configuration
- **`TLC_WALK_FLASH_EN` defined:**
  - In WALK, `walk_lamp` = 1 when count > 2 or count is odd.
  - With T_EXT=3 the per-tick pattern is 1,0,1.
- **`TLC_WALK_FLASH_EN` undefined:**
  - `walk_lamp` is a steady 1 throughout WALK.
- All other behaviour is identical with or without the macro.

## Structure
- Package `tlc_pkg` holds:
  - the state enum (MG, MGX, MY, WALK, SG, SGX, SY)
  - light-code constants LIGHT_R=3'b100, LIGHT_Y=3'b010, LIGHT_G=3'b001
  - default durations
- Sub-module `tlc_interval_timer` has inputs load, load value, tick and reset, and outputs count and expire (tick && count==1).
- The top level holds the FSM, the output decode and the `wr_clear` flop.

## Test plan
- **Reset state:** assert wr_reset mid-run → outputs immediately read main 001, side 100, walk_lamp 0, wr_clear 0.
- **No traffic, no request:** sensor=0, wr=0 → the cycle is MG 6 ticks, MY 2, SG 3, SY 2, MG, i.e. a 13-tick period. walk_lamp and wr_clear are never high.
- **Walk request:** wr=1 from tick 3 → WALK is entered after MY's 2nd tick. wr_clear is high for exactly 1 clk. Both light buses read 100 for 3 ticks, then SG.
- **Sensor extensions:** sensor=1 held → MG 6, MGX 3, MY 2, SG 3, SGX 3, SY 2, i.e. a 19-tick period.
- **Edge-coincident inputs:** wr asserted on the same clk as MY's final tick → WALK is taken. wr asserted 1 clk after that → SG is taken and the request waits for the next cycle.
- **Flash option:** with `TLC_WALK_FLASH_EN`, walk_lamp per WALK tick is 1,0,1. Without it, walk_lamp is 1,1,1.
